// File: rtl/top_processor.sv
// Vector ALU engine: host preloads A/B/opcode memories, engine sweeps all
// addresses writing result[k] = A[k] op[k] B[k]. Optional CYCLE_COUNT_EN adds a sweep cycle counter.
module top_processor #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [ADDR_WIDTH-1:0] addr_data_i,
  input  logic                  ena_data_a_i,
  input  logic                  wea_data_a_i,
  input  logic                  ena_data_b_i,
  input  logic                  wea_data_b_i,
  input  logic                  ena_data_result_i,
  input  logic                  wea_data_result_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic [OP_WIDTH-1:0]   op_i,
  input  logic [ADDR_WIDTH-1:0] addr_op_i,
  input  logic                  ena_op_i,
  input  logic                  wea_op_i,
  input  logic                  start_i,
  output logic                  done_o
`ifdef CYCLE_COUNT_EN
  ,
  output logic [15:0]           cycle_count_o
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int SHW   = $clog2(DATA_WIDTH);

  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_SLL = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_SRL = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_SLT = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(7);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  logic [DATA_WIDTH-1:0] mem_a  [DEPTH];
  logic [DATA_WIDTH-1:0] mem_b  [DEPTH];
  logic [DATA_WIDTH-1:0] mem_r  [DEPTH];
  logic [OP_WIDTH-1:0]   mem_op [DEPTH];

  state_t                state_q;
  logic [ADDR_WIDTH:0]   iss_q;     // MSB set once every address has been issued
  logic                  vld_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] opa_q, opb_q;
  logic [OP_WIDTH-1:0]   op_q;
  logic [DATA_WIDTH-1:0] alu_d;
  logic                  host_en;
  logic                  issue;

  assign host_en = (state_q != S_RUN);
  assign issue   = (state_q == S_RUN) && !iss_q[ADDR_WIDTH];

  always_comb begin
    alu_d = '0;
    case (op_q)
      OP_ADD: alu_d = opa_q + opb_q;
      OP_SUB: alu_d = opa_q - opb_q;
      OP_AND: alu_d = opa_q & opb_q;
      OP_OR:  alu_d = opa_q | opb_q;
      OP_SLL: alu_d = opa_q << opb_q[SHW-1:0];
      OP_SRL: alu_d = opa_q >> opb_q[SHW-1:0];
      OP_SLT: alu_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(opa_q) < $signed(opb_q))};
      OP_XOR: alu_d = opa_q ^ opb_q;
      default: alu_d = '0;
    endcase
  end

  // Memory arrays and read-stage data registers carry no reset.
  always_ff @(posedge CLK) begin
    if (host_en && ena_data_a_i && wea_data_a_i) mem_a[addr_data_i] <= data_i;
    if (host_en && ena_data_b_i && wea_data_b_i) mem_b[addr_data_i] <= data_i;
    if (host_en && ena_op_i && wea_op_i)         mem_op[addr_op_i]  <= op_i;
    if (issue) begin
      opa_q <= mem_a[iss_q[ADDR_WIDTH-1:0]];
      opb_q <= mem_b[iss_q[ADDR_WIDTH-1:0]];
      op_q  <= mem_op[iss_q[ADDR_WIDTH-1:0]];
    end
    if (vld_q)
      mem_r[waddr_q] <= alu_d;
    else if (host_en && ena_data_result_i && wea_data_result_i)
      mem_r[addr_data_i] <= data_i;
  end

`ifdef CYCLE_COUNT_EN
  logic [15:0] cnt_q;
  assign cycle_count_o = cnt_q;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      iss_q   <= '0;
      vld_q   <= 1'b0;
      waddr_q <= '0;
      done_o  <= 1'b0;
      data_o  <= '0;
`ifdef CYCLE_COUNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      vld_q <= issue;
      if (issue) begin
        waddr_q <= iss_q[ADDR_WIDTH-1:0];
        iss_q   <= iss_q + 1'b1;
      end
      if (host_en && ena_data_result_i && !wea_data_result_i)
        data_o <= mem_r[addr_data_i];
      case (state_q)
        S_IDLE: if (start_i) begin
          state_q <= S_RUN;
          iss_q   <= '0;
`ifdef CYCLE_COUNT_EN
          cnt_q   <= '0;
`endif
        end
        S_RUN: begin
`ifdef CYCLE_COUNT_EN
          cnt_q <= cnt_q + 16'd1;
`endif
          if (vld_q && (waddr_q == {ADDR_WIDTH{1'b1}})) begin
            state_q <= S_DONE;
            done_o  <= 1'b1;
          end
        end
        S_DONE: if (!start_i) begin
          state_q <= S_IDLE;
          done_o  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_top_processor.sv
// Directed bench for top_processor: reset, full sweep, read latency, ALU edge cases,
// host writes during a sweep, and reset in the middle of a sweep.
module tb_top_processor;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] data_i = '0;
  logic [9:0]  addr_data_i = '0;
  logic        ena_data_a_i = 0, wea_data_a_i = 0;
  logic        ena_data_b_i = 0, wea_data_b_i = 0;
  logic        ena_data_result_i = 0, wea_data_result_i = 0;
  logic [31:0] data_o;
  logic [2:0]  op_i = '0;
  logic [9:0]  addr_op_i = '0;
  logic        ena_op_i = 0, wea_op_i = 0;
  logic        start_i = 0;
  logic        done_o;
`ifdef CYCLE_COUNT_EN
  logic [15:0] cycle_count_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit edge_mode = 0;
  bit mod_mode  = 0;

  top_processor dut (
    .CLK(CLK), .RST(RST), .data_i(data_i), .addr_data_i(addr_data_i),
    .ena_data_a_i(ena_data_a_i), .wea_data_a_i(wea_data_a_i),
    .ena_data_b_i(ena_data_b_i), .wea_data_b_i(wea_data_b_i),
    .ena_data_result_i(ena_data_result_i), .wea_data_result_i(wea_data_result_i),
    .data_o(data_o), .op_i(op_i), .addr_op_i(addr_op_i),
    .ena_op_i(ena_op_i), .wea_op_i(wea_op_i), .start_i(start_i), .done_o(done_o)
`ifdef CYCLE_COUNT_EN
    , .cycle_count_o(cycle_count_o)
`endif
  );

  always #5 CLK = ~CLK;

  // Hand-derived results for A=1, B=2 per 128-entry opcode block, plus overrides.
  function automatic logic [31:0] exp_val(input int a);
    logic [31:0] blk [8];
    blk = '{32'd3, 32'hFFFF_FFFF, 32'd0, 32'd3, 32'd4, 32'd0, 32'd1, 32'd3};
    if (edge_mode && a == 0) return 32'd1;
    if (edge_mode && a == 1) return 32'h4000_0000;
    if (edge_mode && a == 2) return 32'd0;
    if (edge_mode && a == 3) return 32'd0;
    if (mod_mode && a == 10)  return 32'd0;
    if (mod_mode && a == 900) return 32'hFFFF_FFFF;
    return blk[a / 128];
  endfunction

  task automatic wr_a(input int a, input logic [31:0] v);
    @(negedge CLK);
    addr_data_i = 10'(a); data_i = v; ena_data_a_i = 1; wea_data_a_i = 1;
    @(posedge CLK); #1;
    ena_data_a_i = 0; wea_data_a_i = 0;
  endtask

  task automatic wr_b(input int a, input logic [31:0] v);
    @(negedge CLK);
    addr_data_i = 10'(a); data_i = v; ena_data_b_i = 1; wea_data_b_i = 1;
    @(posedge CLK); #1;
    ena_data_b_i = 0; wea_data_b_i = 0;
  endtask

  task automatic wr_op(input int a, input logic [2:0] v);
    @(negedge CLK);
    addr_op_i = 10'(a); op_i = v; ena_op_i = 1; wea_op_i = 1;
    @(posedge CLK); #1;
    ena_op_i = 0; wea_op_i = 0;
  endtask

  task automatic rd(input int a, output logic [31:0] v);
    @(negedge CLK);
    addr_data_i = 10'(a); ena_data_result_i = 1; wea_data_result_i = 0;
    @(posedge CLK); #1;
    v = data_o;
    ena_data_result_i = 0;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] v;
    for (int a = 0; a < 1024; a++) begin
      rd(a, v);
      n_cmp++;
      if (v !== exp_val(a)) begin
        n_bad++;
        $display("FAIL %s addr=%0d got=%h want=%h", tag, a, v, exp_val(a));
      end
    end
  endtask

  // Start a sweep; optionally inject a host write/read mid-sweep that must be ignored.
  task automatic run_sweep(input string tag, input bit inject);
    int k;
    logic [31:0] held;
    held = data_o;
    @(negedge CLK); start_i = 1;
    @(posedge CLK);
    for (k = 1; k <= 1100; k++) begin
      @(posedge CLK); #1;
      ena_data_a_i = 0; wea_data_a_i = 0; ena_data_result_i = 0;
      if (done_o) break;
      if (inject && k == 500) begin
        addr_data_i = 10'd1023; data_i = 32'd9; ena_data_a_i = 1; wea_data_a_i = 1;
      end
      if (inject && k == 600) begin
        addr_data_i = 10'd5; ena_data_result_i = 1; wea_data_result_i = 0;
      end
      if (inject && k == 602) begin
        n_cmp++;
        if (data_o !== held) begin
          n_bad++;
          $display("FAIL %s data_o_hold_in_run got=%h want=%h", tag, data_o, held);
        end
      end
    end
    n_cmp++;
    if (k !== 1025) begin
      n_bad++;
      $display("FAIL %s done_latency got=%0d want=1025", tag, k);
    end
`ifdef CYCLE_COUNT_EN
    n_cmp++;
    if (cycle_count_o !== 16'd1025) begin
      n_bad++;
      $display("FAIL %s cycle_count got=%0d want=1025", tag, cycle_count_o);
    end
`endif
    repeat (5) @(posedge CLK);
    #1;
    n_cmp++;
    if (done_o !== 1'b1) begin
      n_bad++;
      $display("FAIL %s done_hold got=%b want=1", tag, done_o);
    end
    @(negedge CLK); start_i = 0;
    @(posedge CLK); #1;
    n_cmp++;
    if (done_o !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done_clear got=%b want=0", tag, done_o);
    end
  endtask

  task automatic test_reset;
    RST = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK); #1;
      n_cmp++;
      if (done_o !== 1'b0 || data_o !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_state cyc=%0d done=%b data=%h want done=0 data=0", i, done_o, data_o);
      end
    end
    @(negedge CLK); RST = 1;
    repeat (5) @(posedge CLK);
    #1;
    n_cmp++;
    if (done_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle done=%b want=0", done_o);
    end
  endtask

  task automatic test_full_sweep;
    for (int a = 0; a < 1024; a++) begin
      wr_a(a, 32'd1);
      wr_b(a, 32'd2);
      wr_op(a, 3'(a / 128));
    end
    run_sweep("sweep", 0);
    check_all("sweep_rb");
  endtask

  task automatic test_read_latency;
    logic [31:0] v;
    rd(5, v);
    n_cmp++;
    if (v !== 32'd3) begin
      n_bad++;
      $display("FAIL read_latency got=%h want=3", v);
    end
    @(negedge CLK); addr_data_i = 10'd130;
    @(posedge CLK); #1;
    n_cmp++;
    if (data_o !== 32'd3) begin
      n_bad++;
      $display("FAIL read_hold got=%h want=3", data_o);
    end
  endtask

  task automatic test_edges_and_run_write;
    logic [31:0] v;
    wr_a(0, 32'h8000_0000); wr_b(0, 32'd1);  wr_op(0, 3'd6);
    wr_a(1, 32'h8000_0000); wr_b(1, 32'd1);  wr_op(1, 3'd5);
    wr_a(2, 32'h8000_0000); wr_b(2, 32'd33); wr_op(2, 3'd4);
    wr_a(3, 32'hFFFF_FFFF); wr_b(3, 32'd1);  wr_op(3, 3'd0);
    edge_mode = 1;
    rd(130, v);
    run_sweep("edges", 1);
    check_all("edges_rb");
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] v;
    wr_op(10, 3'd2);
    wr_op(900, 3'd1);
    mod_mode = 1;
    rd(130, v);
    @(negedge CLK); start_i = 1;
    @(posedge CLK);
    repeat (500) @(posedge CLK);
    #3; RST = 0; start_i = 0;
    #1;
    n_cmp++;
    if (done_o !== 1'b0 || data_o !== 32'd0) begin
      n_bad++;
      $display("FAIL mid_reset done=%b data=%h want done=0 data=0", done_o, data_o);
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK); RST = 1;
    run_sweep("restart", 0);
    check_all("restart_rb");
  endtask

  initial begin
    test_reset;
    test_full_sweep;
    test_read_latency;
    test_edges_and_run_write;
    test_reset_mid_run;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/top_processor.md
Name: top_processor

Overview:
- Self-contained vector ALU processor with four on-chip 1024-entry memories: operand A, operand B, opcode, and result.
- A host preloads A, B and per-element opcodes through simple BRAM-style ports, then pulses or holds start_i.
- The engine sweeps all addresses, computing result[k] = A[k] op[k] B[k], and raises done_o when finished.
- The host then reads results back through data_o.

Parameters:
- DATA_WIDTH, 32, width of data words (A, B, result).
- ADDR_WIDTH, 10, address width; depth = 2^ADDR_WIDTH = 1024.
- OP_WIDTH, 3, opcode width.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- data_i  in  DATA_WIDTH  host write data (shared by A, B, result).
- addr_data_i  in  ADDR_WIDTH  host address for A, B, result.
- ena_data_a_i / wea_data_a_i  in  1 each  enable / write-enable for A memory.
- ena_data_b_i / wea_data_b_i  in  1 each  enable / write-enable for B memory.
- ena_data_result_i / wea_data_result_i  in  1 each  enable / write-enable for result memory (read when ena=1, wea=0).
- data_o  out  DATA_WIDTH  registered result-memory read data.
- op_i  in  OP_WIDTH  host opcode write data.
- addr_op_i  in  ADDR_WIDTH  host opcode address.
- ena_op_i / wea_op_i  in  1 each  enable / write-enable for opcode memory.
- start_i  in  1  level start request.
- done_o  out  1  computation complete.

Behaviour:
- Reset (RST=0, async): FSM→IDLE; engine address, pipeline valid, done_o=0, data_o=0. Memory contents are not cleared.
- Host access is honoured only in IDLE and DONE; in RUN, all host writes are ignored and data_o holds its value.
- Write: on a rising edge with ena=1 and wea=1, mem[addr] ← data. Several memories enabled in the same cycle are each written independently.
- Result read: on a rising edge with ena_data_result_i=1 and wea_data_result_i=0, data_o ← result[addr_data_i]; 1-cycle latency. data_o holds otherwise.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN when start_i=1; engine address cleared to 0.
  - RUN: one address issued per cycle, 0..1023. Synchronous read of A/B/op; the next cycle computes and writes result[k].
  - Edge N samples start_i: address k is read at edge N+1+k and result[k] is written at edge N+2+k.
  - At edge N+1025 the last write occurs, FSM→DONE, done_o←1.
  - DONE: done_o stays 1 while start_i=1. DONE→IDLE with done_o←0 when start_i=0.
  - start_i deassert during RUN is ignored; the sweep always completes. Address wrap from 1023 is never used.
- Opcodes (A op B, result is DATA_WIDTH bits, truncated):
  - 0 ADD: A+B.
  - 1 SUB: A−B (two's complement wrap).
  - 2 AND.
  - 3 OR.
  - 4 SLL: A << B[4:0].
  - 5 SRL: logical A >> B[4:0].
  - 6 SLT: 1 if signed A < signed B, else 0.
  - 7 XOR.
- The shift amount uses the low log2(DATA_WIDTH) bits of B.

Optional Feature:
- Macro CYCLE_COUNT_EN.
- When defined:
  - Adds output cycle_count_o [15:0], reset 0.
  - Cleared on the IDLE→RUN transition.
  - Increments every cycle in RUN; holds in DONE/IDLE. Value after a full sweep = 1025.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold RST=0 for 100 cycles → done_o=0, data_o=0; release with start_i=0 → stays IDLE, done_o=0.
- Full sweep:
  - Setup: A[*]=1, B[*]=2; op = ADD at 0–127, SUB at 128–255, AND at 256–383, OR at 384–511, SLL at 512–639, SRL at 640–767, SLT at 768–895, XOR at 896–1023.
  - Assert start_i → done_o rises 1025 edges after sampling.
  - Readback gives 3, 0xFFFFFFFF, 0, 3, 4, 0, 1, 3 per block.
- Read latency: after the sweep, read address 5 → data_o=3 after one edge; deassert ena → data_o holds 3.
- Signed/shift edges:
  - A=0x80000000, B=1 with SLT → 1.
  - SRL → 0x40000000.
  - SLL with B=33 → 0x00000000 (shift 1).
  - ADD 0xFFFFFFFF+1 → 0.
- Host write during RUN: write A[1023]=9 mid-sweep → ignored, result[1023] uses the old A. done_o stays high while start_i=1, then clears after start_i=0.
- Reset mid-RUN: drop RST at address ~500 → done_o=0 immediately, FSM IDLE. A new start completes with correct results everywhere.
